// File: rtl/restoring_divider_seq_pkg.sv
// Shared definitions for the sequential restoring divider: default operand
// widths, iteration counter width and the controller state encoding.
package divider_pkg;

  localparam int DIVIDEND_W_DEF = 6;
  localparam int DIVISOR_W_DEF  = 3;

  // Counter runs DIVIDEND_W-1 down to 0, so it needs clog2(DIVIDEND_W) bits.
  localparam int CNT_W = $clog2(DIVIDEND_W_DEF);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/restoring_divider_seq_if.sv
// Request/result bundle for the restoring divider. The master issues
// operands with start; the slave returns busy/done and the held results.
interface restoring_divider_seq_if
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_seq_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor, keep the difference only
// when it does not go negative. Purely combinational.
module divider_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W-1:0] pr,
  input  logic                 dvd_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] pr_next,
  output logic                 qbit
);

  logic [DIVISOR_W:0]   trial;
  logic [DIVISOR_W-1:0] diff;

  // Incoming pr is always below divisor, so trial < 2*divisor and the
  // difference fits in DIVISOR_W bits; low-order modular subtraction suffices.
  always_comb begin
    trial   = {pr, dvd_bit};
    diff    = trial[DIVISOR_W-1:0] - divisor;
    qbit    = (trial >= {1'b0, divisor});
    pr_next = qbit ? diff : trial[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/restoring_divider_seq.sv
// Iterative unsigned restoring divider, one quotient bit per clock, MSB first.
// Optional build macro DIV_EARLY_TERM_EN: when dividend < divisor the
// iterations are skipped and the result is produced one edge after accept.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | waiting for start; results from last operation held
// RUN   | iterating, one quotient bit per edge; start ignored
// DONE  | one-cycle done pulse; start here is accepted back-to-back
module restoring_divider_seq
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                   clk,
  input  logic                   rst,
  restoring_divider_seq_if.slave bus
);

  state_t state, state_next;

  logic                  accept;
  logic                  zero_div;
  logic                  early;
  logic [CNT_W-1:0]      count;
  logic [DIVIDEND_W-1:0] dvd_sh;
  logic [DIVISOR_W-1:0]  dsr;
  logic [DIVISOR_W-1:0]  pr;
  logic [DIVISOR_W-1:0]  pr_next;
  logic                  qbit;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dbz_q;

  assign zero_div = (bus.divisor == '0);

`ifdef DIV_EARLY_TERM_EN
  assign early = !zero_div && (bus.dividend < DIVIDEND_W'(bus.divisor));
`else
  assign early = 1'b0;
`endif

  divider_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .pr      (pr),
    .dvd_bit (dvd_sh[DIVIDEND_W-1]),
    .divisor (dsr),
    .pr_next (pr_next),
    .qbit    (qbit)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next-state and accept decode; operations that need no iterations go
  // straight to DONE.
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.start) begin
          accept     = 1'b1;
          state_next = (zero_div || early) ? DONE : RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        if (count == '0) state_next = DONE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand capture on accept, one shift/subtract per RUN edge.
  // The dividend shift register fills with quotient bits from the LSB, so
  // after the last iteration it holds the full quotient.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd_sh      <= '0;
      dsr         <= '0;
      pr          <= '0;
      count       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      dvd_sh <= bus.dividend;
      dsr    <= bus.divisor;
      pr     <= '0;
      count  <= CNT_W'(DIVIDEND_W - 1);
      dbz_q  <= zero_div;
      if (zero_div) begin
        quotient_q  <= '1;
        remainder_q <= '0;
      end else if (early) begin
        quotient_q  <= '0;
        remainder_q <= bus.dividend[DIVISOR_W-1:0];
      end
    end else if (state == RUN) begin
      dvd_sh <= {dvd_sh[DIVIDEND_W-2:0], qbit};
      pr     <= pr_next;
      count  <= count - CNT_W'(1);
      if (count == '0) begin
        quotient_q  <= {dvd_sh[DIVIDEND_W-2:0], qbit};
        remainder_q <= pr_next;
      end
    end
  end

  assign bus.busy        = (state == RUN);
  assign bus.done        = (state == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider_seq.sv
// Scoreboard bench for restoring_divider_seq: stimulus pushes expected
// results with the cycle they are due; a negedge monitor pops on done.
module tb_restoring_divider_seq;
  import divider_pkg::*;

  localparam int AW = 6;
  localparam int BW = 3;

  typedef struct {
    int           a;
    int           b;
    logic [AW-1:0] q;
    logic [BW-1:0] r;
    logic          dbz;
    int            due;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  exp_t sb[$];
  exp_t mon_e;

  restoring_divider_seq_if #(.DIVIDEND_W(AW), .DIVISOR_W(BW)) bus();

  restoring_divider_seq #(.DIVIDEND_W(AW), .DIVISOR_W(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int lat(input int a, input int b);
    if (b == 0) return 1;
`ifdef DIV_EARLY_TERM_EN
    if (a < b) return 1;
`endif
    return AW + 1;
  endfunction

  // Waits for the divider to be able to accept, then presents one request.
  task automatic issue(input int a, input int b, input int q, input int r, input int dbz);
    exp_t e;
    int   guard = 0;
    while (bus.busy && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (bus.busy) begin
      tests++;
      fails++;
      $display("FAIL issue_timeout: busy stuck high, expected idle within 50 cycles");
      return;
    end
    bus.start    = 1'b1;
    bus.dividend = AW'(a);
    bus.divisor  = BW'(b);
    e.a = a; e.b = b;
    e.q = AW'(q); e.r = BW'(r); e.dbz = dbz[0];
    e.due = cyc + lat(a, b);
    sb.push_back(e);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    #1;
    while (sb.size() != 0 && guard < 100) begin
      @(negedge clk);
      #1;
      guard++;
    end
    if (sb.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: %0d results pending, expected 0", sb.size());
      sb.delete();
    end
    @(negedge clk);
    chk("done_one_cycle", int'(bus.done), 0);
  endtask

  // Monitor: every done must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!rst && bus.done) begin
      chk("busy_with_done", int'(bus.busy), 0);
      if (sb.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_done: got done=1 expected no pending result (cycle %0d)", cyc);
      end else begin
        mon_e = sb.pop_front();
        chk($sformatf("quotient %0d/%0d", mon_e.a, mon_e.b), int'(bus.quotient), int'(mon_e.q));
        chk($sformatf("remainder %0d/%0d", mon_e.a, mon_e.b), int'(bus.remainder), int'(mon_e.r));
        chk($sformatf("div_by_zero %0d/%0d", mon_e.a, mon_e.b), int'(bus.div_by_zero), int'(mon_e.dbz));
        chk($sformatf("latency %0d/%0d", mon_e.a, mon_e.b), cyc, mon_e.due);
      end
    end
  end

  initial begin
    int saw_done;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    repeat (3) @(negedge clk);

    chk("reset_busy", int'(bus.busy), 0);
    chk("reset_done", int'(bus.done), 0);
    chk("reset_quotient", int'(bus.quotient), 0);
    chk("reset_remainder", int'(bus.remainder), 0);
    chk("reset_dbz", int'(bus.div_by_zero), 0);
    rst = 1'b0;
    @(negedge clk);

    issue(45, 6, 7, 3, 0);   drain();
    issue(63, 7, 9, 0, 0);   drain();
    issue(0, 5, 0, 0, 0);    drain();
    issue(5, 0, 63, 0, 1);   drain();
    issue(8, 2, 4, 0, 0);    drain();
    issue(2, 5, 0, 2, 0);    drain();

    // start with different operands during RUN must be ignored
    issue(45, 6, 7, 3, 0);
    repeat (2) @(negedge clk);
    bus.start    = 1'b1;
    bus.dividend = 6'd7;
    bus.divisor  = 3'd1;
    @(negedge clk);
    bus.start = 1'b0;
    drain();

    // second request accepted in the DONE cycle
    issue(63, 7, 9, 0, 0);
    issue(20, 3, 6, 2, 0);
    drain();

    // reset in the middle of RUN aborts without a done pulse
    issue(45, 6, 7, 3, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("abort_busy", int'(bus.busy), 0);
    chk("abort_done", int'(bus.done), 0);
    chk("abort_quotient", int'(bus.quotient), 0);
    chk("abort_remainder", int'(bus.remainder), 0);
    chk("abort_dbz", int'(bus.div_by_zero), 0);
    sb.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    saw_done = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done) saw_done = 1;
    end
    chk("no_done_after_abort", saw_done, 0);

    // full operand sweep, issued back-to-back
    for (int a = 0; a < 64; a++) begin
      for (int b = 0; b < 8; b++) begin
        if (b == 0) issue(a, b, 63, 0, 1);
        else        issue(a, b, a / b, a % b, 0);
      end
    end
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
